cz80_alu16_seq: RTL and testbench

//  Sequencer for 16-bit arithmetic (ADD HL,rr / ADC HL,rr / SBC HL,rr) over the 8-bit cz80_alu.

---
 rtl/cz80_alu16_seq.sv | 127 ++++++++++++
 tb/tb_cz80_alu16_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cz80_alu16_seq.sv
// cz80_alu16_seq: runs ADD/ADC/SBC HL,rr as a low-byte then high-byte pass over the 8-bit cz80_alu.
// Define CZ80_ALU16_SUB_EN to enable op=3 (SUB16); otherwise op=3 passes opa/f_in through unchanged.
module cz80_alu16_seq #(
  parameter int ALU_LAT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic [7:0]  f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  f_out,
  output logic [3:0]  alu_op,
  output logic        arith16,
  output logic        z16,
  output logic [7:0]  busa,
  output logic [7:0]  busb,
  output logic [7:0]  alu_f_in,
  input  logic [7:0]  alu_q,
  input  logic [7:0]  alu_f_out,
  output logic        alu_cpi,
  output logic [7:0]  ir,
  output logic [1:0]  iset
);
`ifdef CZ80_ALU16_SUB_EN
  localparam logic SUB_EN = 1'b1;
`else
  localparam logic SUB_EN = 1'b0;
`endif
  localparam logic [1:0] LAT = 2'(ALU_LAT);
  typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;
  state_t state, nxt;
  logic [1:0] cnt, op_r, op_s;
  logic [15:0] a_r, b_r, a_s, b_s;
  logic [7:0] fi_r, f_s, a_d, b_d, f_d;
  logic [3:0] op_d;
  logic last, ill, ar_d, z_d;
  assign last = cnt == LAT;
  // Operands come straight from the ports on the accepting edge, from the latches afterwards
  assign op_s = state == IDLE ? op : op_r;
  assign a_s = state == IDLE ? opa : a_r;
  assign b_s = state == IDLE ? opb : b_r;
  assign f_s = state == IDLE ? f_in : fi_r;
  assign ill = op_s == 2'd3 && !SUB_EN;
  assign busy = state == LO || state == HI;
  assign done = state == FIN;
  assign alu_cpi = 1'b0;
  assign ir = '0;
  assign iset = '0;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? LO : IDLE;
      LO: nxt = last ? HI : LO;
      HI: nxt = last ? FIN : HI;
      default: nxt = IDLE;
    endcase
  end
  // High pass takes the low pass flags live, since they are captured on the same edge
  always_comb begin
    op_d = '0;
    ar_d = 1'b0;
    z_d = 1'b0;
    a_d = '0;
    b_d = '0;
    f_d = '0;
    if (nxt == LO && !ill) begin
      op_d = op_s == 2'd2 ? 4'd3 : op_s == 2'd3 ? 4'd2 : {2'b00, op_s};
      a_d = a_s[7:0];
      b_d = b_s[7:0];
      f_d = f_s;
    end else if (nxt == HI && !ill) begin
      op_d = op_s[1] ? 4'd3 : 4'd1;
      ar_d = op_s == 2'd0;
      z_d = op_s != 2'd0;
      a_d = a_s[15:8];
      b_d = b_s[15:8];
      f_d = alu_f_out;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      fi_r <= '0;
      result <= '0;
      f_out <= '0;
      alu_op <= '0;
      arith16 <= 1'b0;
      z16 <= 1'b0;
      busa <= '0;
      busb <= '0;
      alu_f_in <= '0;
    end else begin
      state <= nxt;
      cnt <= (state == nxt && busy) ? cnt + 2'd1 : 2'd0;
      if (state == IDLE && start) begin
        op_r <= op;
        a_r <= opa;
        b_r <= opb;
        fi_r <= f_in;
      end
      if (nxt != state) begin
        alu_op <= op_d;
        arith16 <= ar_d;
        z16 <= z_d;
        busa <= a_d;
        busb <= b_d;
        alu_f_in <= f_d;
      end
      if (state == LO && last) result[7:0] <= ill ? a_r[7:0] : alu_q;
      // ADD16 keeps S, Z, PV of the original F; Y/X follow the high result byte
      if (state == HI && last) begin
        result[15:8] <= ill ? a_r[15:8] : alu_q;
        f_out <= ill ? fi_r : op_r == 2'd0 ?
          {fi_r[7:6], alu_q[5], alu_f_out[4], alu_q[3], fi_r[2], 1'b0, alu_f_out[0]} : alu_f_out;
      end
    end
  end
endmodule

// File: tb/tb_cz80_alu16_seq.sv
// tb_cz80_alu16_seq: directed and swept checks of cz80_alu16_seq against a behavioural 8-bit ALU
// and an independent 16-bit Z80 arithmetic model, for ALU_LAT=0 and ALU_LAT=2.
module tb_cz80_alu16_seq;
  logic clk = 1'b0, reset = 1'b1, start0 = 1'b0, start2 = 1'b0;
  logic [1:0] op = '0;
  logic [15:0] opa = '0, opb = '0;
  logic [7:0] f_in = '0;
  logic busy0, done0, busy2, done2, ar0, ar2, z0, z2, cpi0, cpi2;
  logic [15:0] res0, res2, p1, p2;
  logic [7:0] fo0, fo2, a0, a2, b0, b2, fi0, fi2, q0, q2, fq0, fq2, ir0, ir2;
  logic [3:0] aop0, aop2;
  logic [1:0] is0, is2;
  logic [15:0] vals [8] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h00FF, 16'h0F0F, 16'h1234, 16'hFFFE};
  logic [7:0] fv [4] = '{8'h00, 8'hFF, 8'h01, 8'hC4};
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu8(input logic [3:0] o, input logic [7:0] a, b, fi, input logic ar, z);
    logic [8:0] s;
    logic [4:0] h;
    logic c, v;
    logic [7:0] f;
    c = o[0] & fi[0];
    s = o[1] ? 9'(a) - 9'(b) - 9'(c) : 9'(a) + 9'(b) + 9'(c);
    h = o[1] ? 5'(a[3:0]) - 5'(b[3:0]) - 5'(c) : 5'(a[3:0]) + 5'(b[3:0]) + 5'(c);
    v = (o[1] ? a[7] != b[7] : a[7] == b[7]) && s[7] != a[7];
    f = {s[7], s[7:0] == 8'h00 && (!z || fi[6]), s[5], h[4], s[3], v, o[1], s[8]};
    if (ar) f = {fi[7:6], f[5:3], fi[2], f[1:0]};
    return {s[7:0], f};
  endfunction

  function automatic logic [23:0] ref16(input logic [1:0] o, input logic [15:0] a, b, input logic [7:0] fi);
    logic [16:0] r;
    logic [12:0] h;
    logic c, v, sub;
`ifndef CZ80_ALU16_SUB_EN
    if (o == 2'd3) return {a, fi};
`endif
    sub = o[1];
    c = (o == 2'd1 || o == 2'd2) && fi[0];
    r = sub ? 17'(a) - 17'(b) - 17'(c) : 17'(a) + 17'(b) + 17'(c);
    h = sub ? 13'(a[11:0]) - 13'(b[11:0]) - 13'(c) : 13'(a[11:0]) + 13'(b[11:0]) + 13'(c);
    v = (sub ? a[15] != b[15] : a[15] == b[15]) && r[15] != a[15];
    if (o == 2'd0) return {r[15:0], fi[7:6], r[13], h[12], r[11], fi[2], 1'b0, r[16]};
    return {r[15:0], r[15], r[15:0] == 16'h0000, r[13], h[12], r[11], v, sub, r[16]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  cz80_alu16_seq #(.ALU_LAT(0)) u0 (
    .clk(clk), .reset(reset), .start(start0), .op(op), .opa(opa), .opb(opb), .f_in(f_in),
    .busy(busy0), .done(done0), .result(res0), .f_out(fo0), .alu_op(aop0), .arith16(ar0), .z16(z0),
    .busa(a0), .busb(b0), .alu_f_in(fi0), .alu_q(q0), .alu_f_out(fq0), .alu_cpi(cpi0), .ir(ir0), .iset(is0));
  cz80_alu16_seq #(.ALU_LAT(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .op(op), .opa(opa), .opb(opb), .f_in(f_in),
    .busy(busy2), .done(done2), .result(res2), .f_out(fo2), .alu_op(aop2), .arith16(ar2), .z16(z2),
    .busa(a2), .busb(b2), .alu_f_in(fi2), .alu_q(q2), .alu_f_out(fq2), .alu_cpi(cpi2), .ir(ir2), .iset(is2));

  assign {q0, fq0} = alu8(aop0, a0, b0, fi0, ar0, z0);
  always @(posedge clk) begin
    p1 <= alu8(aop2, a2, b2, fi2, ar2, z2);
    p2 <= p1;
  end
  assign {q2, fq2} = p2;

  task automatic run(input bit sel, input logic [1:0] o, input logic [15:0] a, b, input logic [7:0] fi,
                     output int lat, output logic [15:0] r, output logic [7:0] f);
    op = o; opa = a; opb = b; f_in = fi;
    if (sel) start2 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start2 = 1'b0;
    opa = ~a; opb = a ^ b; f_in = ~fi; op = ~o;
    lat = 1;
    while (!(sel ? done2 : done0) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = sel ? res2 : res0;
    f = sel ? fo2 : fo0;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, nd;
    logic [15:0] r;
    logic [7:0] f;
    logic [23:0] e;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_result", {res0, fo0}, 0);
    check("rst_drive", |{aop0, ar0, z0, a0, b0, fi0, cpi0, ir0, is0}, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy0, 0);
    run(0, 2'd0, 16'h0FFF, 16'h0001, 8'hC4, lat, r, f);
    check("add_lat", lat, 3);
    check("add_res", r, 16'h1000);
    check("add_f", f, 8'hD4);
    run(0, 2'd1, 16'hFFFF, 16'h0000, 8'h01, lat, r, f);
    check("adc_res", r, 16'h0000);
    check("adc_f", f, 8'h51);
    run(0, 2'd2, 16'h8000, 16'h0001, 8'h00, lat, r, f);
    check("sbc_res", r, 16'h7FFF);
    check("sbc_f", f, 8'h3E);
    run(0, 2'd3, 16'h1000, 16'h0001, 8'h01, lat, r, f);
    check("op3_lat", lat, 3);
`ifdef CZ80_ALU16_SUB_EN
    check("sub_res", r, 16'h0FFF);
    check("sub_f", f, 8'h1A);
`else
    check("op3_res", r, 16'h1000);
    check("op3_f", f, 8'h01);
`endif
    op = 2'd2; opa = 16'h8000; opb = 16'h0001; f_in = 8'h00; start0 = 1'b1;
    @(posedge clk); #1;
    nd = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 1) check("lo_drive", {aop0, z0, a0, b0}, {4'd3, 1'b0, 8'h00, 8'h01});
      if (c == 2) check("hi_drive", {aop0, z0, ar0, a0, b0}, {4'd3, 1'b1, 1'b0, 8'h80, 8'h00});
      if (c == 4) check("held_idle_busy", busy0, 0);
      if (c == 5) check("held_reaccept_busy", busy0, 1);
      nd += int'(done0);
      if (c < 6) begin @(posedge clk); #1; end
    end
    check("held_one_done", nd, 1);
    start0 = 1'b0;
    @(posedge clk); #1;
    check("held_second_done", {done0, res0}, {1'b1, 16'h7FFF});
    @(posedge clk); #1;
    op = 2'd0; opa = 16'h1234; opb = 16'h4321; f_in = 8'h00; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", busy0, 1);
    reset = 1'b1;
    #1;
    check("midrst_busy_done", {busy0, done0}, 0);
    check("midrst_result", {res0, fo0}, 0);
    check("midrst_drive", |{aop0, ar0, z0, a0, b0, fi0}, 0);
    @(negedge clk); reset = 1'b0;
    nd = 0;
    repeat (6) begin @(posedge clk); #1; nd += int'(done0); end
    check("midrst_no_done", nd, 0);
    run(1, 2'd0, 16'h1234, 16'h1111, 8'h00, lat, r, f);
    check("lat2_lat", lat, 7);
    check("lat2_res", r, 16'h2345);
    check("lat2_f", f, 8'h20);
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) begin
          e = ref16(2'(k), vals[i], vals[j], fv[(i + j) % 4]);
          run(0, 2'(k), vals[i], vals[j], fv[(i + j) % 4], lat, r, f);
          check("sw0_lat", lat, 3);
          check("sw0_res", r, e[23:8]);
          check("sw0_f", f, e[7:0]);
          if (i == j || i + j == 7) begin
            run(1, 2'(k), vals[i], vals[j], fv[(i + j) % 4], lat, r, f);
            check("sw2_lat", lat, 7);
            check("sw2_res", r, e[23:8]);
            check("sw2_f", f, e[7:0]);
          end
        end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
